// File: rtl/lsq_ring.sv
// lsq_ring: in-order load/store queue sitting between dispatch, the CDB, the
// ROB and the memory controller.
//
// A ring of DEPTH slots. Slot i always carries tag TAG_BASE+i. Operands that
// are still outstanding are woken from the CDB, and a matching broadcast in the
// allocation cycle is bypassed straight into the new slot. Only the head slot
// may access memory. A store waits for its ROB commit before it issues. A flush
// drops every entry except committed stores.
//
// Opcode encoding on alloc_op (any other value is ignored):
//   0 LB  1 LH  2 LW  3 LBU  4 LHU  5 SB  6 SH  7 SW
//
// Ports
//   clk_in, rst_in, rdy_in      clock, sync active-high reset, global stall (0 = freeze)
//   alloc_*                     dispatch offer; alloc_stall/alloc_tag returned combinationally
//   cdb_active/tag/val          result broadcast used for operand wakeup
//   commit_valid/tag            ROB commit, marks a store as safe to issue
//   flush_in                    mispredict flush
//   mem_req/rnw/type/addr/wdata request to memory, held until mem_done
//   mem_done/mem_rdata          memory completion
//   res_valid/tag/val           one-cycle load result
//   count                       occupied slots
module lsq_ring #(
  parameter int DEPTH    = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 4,
  parameter int NONE_TAG = 0,
  parameter int XLEN     = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_op,
  input  logic [XLEN-1:0]  alloc_imm,
  input  logic [XLEN-1:0]  alloc_vj,
  input  logic [XLEN-1:0]  alloc_vk,
  input  logic [TAG_W-1:0] alloc_qj,
  input  logic [TAG_W-1:0] alloc_qk,
  output logic             alloc_stall,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_active,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             flush_in,
  output logic             mem_req,
  output logic             mem_rnw,
  output logic [2:0]       mem_type,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_done,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [XLEN-1:0]  res_val,
  output logic [IDX_W:0]   count
);

  localparam logic [4:0]       OP_LHU = 5'd4;
  localparam logic [4:0]       OP_SW  = 5'd7;
  localparam logic [TAG_W-1:0] NONE   = TAG_W'(NONE_TAG);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_e;

  function automatic logic op_is_ls(input logic [4:0] op);
    return (op <= OP_SW);
  endfunction

  function automatic logic op_is_load(input logic [4:0] op);
    return (op <= OP_LHU);
  endfunction

  // [1:0] 00 word / 01 half / 10 byte, [2] sign-extend
  function automatic logic [2:0] op_type(input logic [4:0] op);
    logic [2:0] t;
    case (op)
      5'd0:    t = 3'b110; // LB
      5'd1:    t = 3'b101; // LH
      5'd3:    t = 3'b010; // LBU
      5'd4:    t = 3'b001; // LHU
      5'd5:    t = 3'b010; // SB
      5'd6:    t = 3'b001; // SH
      default: t = 3'b000; // LW, SW
    endcase
    return t;
  endfunction

  function automatic logic [TAG_W-1:0] slot_tag(input logic [IDX_W-1:0] idx);
    return TAG_W'(TAG_BASE) + TAG_W'(idx);
  endfunction

  // Ring addition; idx < DEPTH and n <= DEPTH, so one conditional subtract suffices.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W:0]   n);
    logic [IDX_W+1:0] sum;
    sum = {2'b00, idx} + {1'b0, n};
    sum = (sum >= (IDX_W+2)'(DEPTH)) ? (sum - (IDX_W+2)'(DEPTH)) : sum;
    return sum[IDX_W-1:0];
  endfunction

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]       count_q, count_d;
  logic [DEPTH-1:0]     valid_q, valid_d, load_q, load_d, cmt_q, cmt_d;
  logic [2:0]           type_q [DEPTH];
  logic [2:0]           type_d [DEPTH];
  logic [XLEN-1:0]      imm_q  [DEPTH];
  logic [XLEN-1:0]      imm_d  [DEPTH];
  logic [XLEN-1:0]      vj_q   [DEPTH];
  logic [XLEN-1:0]      vj_d   [DEPTH];
  logic [XLEN-1:0]      vk_q   [DEPTH];
  logic [XLEN-1:0]      vk_d   [DEPTH];
  logic [TAG_W-1:0]     qj_q   [DEPTH];
  logic [TAG_W-1:0]     qj_d   [DEPTH];
  logic [TAG_W-1:0]     qk_q   [DEPTH];
  logic [TAG_W-1:0]     qk_d   [DEPTH];

  logic                 mem_req_q, mem_req_d, mem_rnw_q, mem_rnw_d;
  logic [2:0]           mem_type_q, mem_type_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                 res_valid_q, res_valid_d;
  logic [TAG_W-1:0]     res_tag_q, res_tag_d;
  logic [XLEN-1:0]      res_val_q, res_val_d;

  logic                 alloc_ls_s, full_s, alloc_ok_s, cdb_ok_s, pop_s;
  logic [TAG_W-1:0]     in_qk_s;
  logic [IDX_W:0]       cs_s;

  assign alloc_ls_s  = alloc_valid && op_is_ls(alloc_op);
  assign full_s      = (count_q == (IDX_W+1)'(DEPTH));
  // Flush and reset both win over a same-cycle allocation.
  assign alloc_ok_s  = alloc_ls_s && !full_s && rdy_in && !flush_in && !rst_in;
  assign alloc_stall = alloc_ls_s && full_s;
  assign alloc_tag   = alloc_ok_s ? slot_tag(tail_q) : NONE;
  // A broadcast of the "no producer" tag must never overwrite ready operands.
  assign cdb_ok_s    = cdb_active && (cdb_tag != NONE);
  assign in_qk_s     = op_is_load(alloc_op) ? NONE : alloc_qk;

  // Next-state logic: wakeup, commit, memory FSM, pop, allocate, then flush.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    load_d      = load_q;
    cmt_d       = cmt_q;
    type_d      = type_q;
    imm_d       = imm_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    mem_req_d   = mem_req_q;
    mem_rnw_d   = mem_rnw_q;
    mem_type_d  = mem_type_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    res_valid_d = 1'b0;
    res_tag_d   = res_tag_q;
    res_val_d   = res_val_q;
    pop_s       = 1'b0;
    cs_s        = '0;

    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_ok_s && (qj_q[i] == cdb_tag)) begin
          vj_d[i] = cdb_val;
          qj_d[i] = NONE;
        end else begin
          qj_d[i] = qj_q[i];
        end
        if (valid_q[i] && cdb_ok_s && (qk_q[i] == cdb_tag)) begin
          vk_d[i] = cdb_val;
          qk_d[i] = NONE;
        end else begin
          qk_d[i] = qk_q[i];
        end
        if (commit_valid && valid_q[i] && !load_q[i] &&
            (commit_tag == slot_tag(IDX_W'(i)))) begin
          cmt_d[i] = 1'b1;
        end else begin
          cmt_d[i] = cmt_q[i];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (!flush_in && valid_q[head_q] && (qj_q[head_q] == NONE) &&
              (qk_q[head_q] == NONE) && (load_q[head_q] || cmt_q[head_q])) begin
            mem_req_d   = 1'b1;
            mem_rnw_d   = load_q[head_q];
            mem_type_d  = type_q[head_q];
            mem_addr_d  = vj_q[head_q] + imm_q[head_q];
            mem_wdata_d = vk_q[head_q];
            state_d     = S_BUSY;
          end else begin
            state_d     = S_IDLE;
          end
        end
        S_BUSY: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
            // A load finishing in the flush cycle is simply dropped; flush
            // invalidates its slot and no pop is needed.
            if (!(mem_rnw_q && flush_in)) begin
              pop_s       = 1'b1;
              res_valid_d = mem_rnw_q;
              res_tag_d   = slot_tag(head_q);
              res_val_d   = mem_rdata;
            end else begin
              pop_s       = 1'b0;
            end
          end else if (flush_in && mem_rnw_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_DRAIN: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            state_d   = S_DRAIN;
          end
        end
        default: begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      endcase

      if (pop_s) begin
        valid_d[head_q] = 1'b0;
        head_d          = wrap_add(head_q, (IDX_W+1)'(1));
      end else begin
        head_d          = head_q;
      end

      // Tail never equals the popped head here: alloc needs !full, pop needs !empty.
      if (alloc_ok_s) begin
        valid_d[tail_q] = 1'b1;
        load_d[tail_q]  = op_is_load(alloc_op);
        cmt_d[tail_q]   = 1'b0;
        type_d[tail_q]  = op_type(alloc_op);
        imm_d[tail_q]   = alloc_imm;
        if (cdb_ok_s && (alloc_qj == cdb_tag)) begin
          vj_d[tail_q] = cdb_val;
          qj_d[tail_q] = NONE;
        end else begin
          vj_d[tail_q] = alloc_vj;
          qj_d[tail_q] = alloc_qj;
        end
        if (cdb_ok_s && (in_qk_s == cdb_tag)) begin
          vk_d[tail_q] = cdb_val;
          qk_d[tail_q] = NONE;
        end else begin
          vk_d[tail_q] = alloc_vk;
          qk_d[tail_q] = in_qk_s;
        end
        tail_d = wrap_add(tail_q, (IDX_W+1)'(1));
      end else begin
        tail_d = tail_q;
      end

      count_d = count_q + (IDX_W+1)'(alloc_ok_s) - (IDX_W+1)'(pop_s);

      // Committed stores sit contiguously at the head, so the survivors
      // occupy head..head+cs-1 after the flush.
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_d[i] && !load_d[i] && cmt_d[i]) begin
            cs_s = cs_s + (IDX_W+1)'(1);
          end else begin
            valid_d[i] = 1'b0;
          end
        end
        tail_d  = wrap_add(head_d, cs_s);
        count_d = cs_s;
      end else begin
        count_d = count_d;
      end
    end else begin
      res_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      load_q      <= '0;
      cmt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= 3'b000;
        imm_q[i]  <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= NONE;
        qk_q[i]   <= NONE;
      end
      mem_req_q   <= 1'b0;
      mem_rnw_q   <= 1'b0;
      mem_type_q  <= 3'b000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= NONE;
      res_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      load_q      <= load_d;
      cmt_q       <= cmt_d;
      type_q      <= type_d;
      imm_q       <= imm_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      mem_req_q   <= mem_req_d;
      mem_rnw_q   <= mem_rnw_d;
      mem_type_q  <= mem_type_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_val_q   <= res_val_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_rnw   = mem_rnw_q;
  assign mem_type  = mem_type_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_val   = res_val_q;
  assign count     = count_q;

endmodule
